ntt_addr_sequencer: RTL and testbench
=====================================

Name: ntt_addr_sequencer

Overview:
- Control sequencer for the Dilithium NTT/INTT butterfly datapath; replaces hand-wired chains of up/down counters for layer, group and offset.
- On a start pulse, walks all butterfly pairs layer by layer, emitting (addr_a, addr_b, zeta_idx) once per accepted beat over a valid/ready handshake.
- In inverse mode it appends a 256-beat scaling pass (multiply by N^-1 · mont).
- Sits between the top-level polynomial controller and the coefficient RAM / twiddle ROM / butterfly unit.

Parameters:
- LOG_N, 8, log2 of polynomial length (N = 2^LOG_N = 256); number of layers = LOG_N.
- ADDR_W, 8, coefficient address width (= LOG_N).

Ports:
- clk       in   1       clock, rising edge
- rst       in   1       asynchronous, active-high reset
- start     in   1       single-cycle request to begin a transform; sampled only in IDLE
- inverse   in   1       mode, latched with start: 0 = forward NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande) + scaling
- ready     in   1       downstream accepts the current beat
- valid     out  1       current addr_a/addr_b/zeta_idx/scale are meaningful
- addr_a    out  ADDR_W  first coefficient address
- addr_b    out  ADDR_W  second coefficient address (= addr_a + len); equals addr_a during scaling
- zeta_idx  out  ADDR_W  twiddle ROM index (1..255); 0 during scaling
- layer     out  3       current layer 0..LOG_N-1; 0 during scaling
- scale     out  1       high on scaling-pass beats
- busy      out  1       high from the cycle after start accepted until done
- done      out  1       one-cycle pulse after the final accepted beat

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0; internal counters 0; latched mode 0.
- FSM states and transitions:
  - IDLE -> BFLY when start=1.
  - BFLY -> SCALE when the last butterfly beat of layer LOG_N-1 is accepted and mode=inverse.
  - BFLY -> FIN when that beat is accepted and mode=forward.
  - SCALE -> FIN when beat 255 is accepted.
  - FIN -> IDLE unconditionally; done=1 only in FIN.
- Latency and outputs:
  - All outputs registered.
  - valid rises the cycle after start is sampled; busy rises in the same cycle.
- Internal counters:
  - layer l in 0..LOG_N-1.
  - butterfly count b in 0..N/2-1.
  - Derived: len = 2^(7-l) forward, 2^l inverse; group = b >> log2(len); off = b & (len-1).
- Address and twiddle generation:
  - addr_a = group·2·len + off; addr_b = addr_a + len.
  - zeta_idx forward = 2^l + group.
  - zeta_idx inverse = 2^(8-l) - 1 - group.
  - All arithmetic in ADDR_W bits with no overflow for legal values.
- Handshake and advance:
  - A beat is accepted on a clock edge where valid & ready.
  - Accepted beat: b++. b wraps 127->0 with l++, and l wraps 7 -> SCALE/FIN.
  - valid=1 & ready=0: all outputs hold stable (no change while stalled).
  - valid never drops mid-transform without an accept.
- Scaling pass: index s 0..255; addr_a = addr_b = s, scale=1, zeta_idx=0, layer=0.
- Beat counts: 1024 accepted beats for forward; 1024 + 256 for inverse.
- Ignored inputs: start while busy or in FIN is ignored; inverse is sampled only with an accepted start.
- Back-to-back: start asserted in the cycle done=1 is ignored (FSM not yet in IDLE); start is accepted from the next cycle.
- FIN timing: valid=0, busy=0 and done=1 in FIN.
- Reset mid-transform: immediate return to IDLE, outputs 0, no done pulse.

Test Plan:
- Forward, ready=1: start, inverse=0 ->
  - beat0 (0,128,zeta 1, layer 0); beat1 (1,129,1).
  - beat128 (0,64,2, layer 1); beat192 (128,192,3).
  - beat1023 (254,255,255, layer 7).
  - done pulse exactly 1 cycle after beat1023; 1024 beats total.
- Inverse, ready=1: start, inverse=1 ->
  - beat0 (0,1,255); beat1 (2,3,254).
  - beat1023 (127,255,1, layer 7).
  - beats 1024..1279 scale=1 with addr 0..255.
  - done after 1280 beats.
- Backpressure: ready low for 5 cycles at beat 300 -> outputs frozen at beat 300 values; resumes with beat 301; total beats unchanged.
- Start while busy (pulse at beat 50, inverse=1) -> ignored; mode stays forward; sequence unchanged.
- Async rst asserted mid-layer 3 (between clock edges) -> outputs 0 immediately; no done; a fresh start afterwards restarts at (0,128,1).
- Back-to-back: start in done cycle ignored; start next cycle -> valid one cycle later with beat0 of the new mode.

Source files
------------

// File: rtl/ntt_addr_sequencer_if.sv
// rtl/ntt_addr_sequencer_if.sv - beat handshake bundle between polynomial controller and NTT address sequencer
interface ntt_addr_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int LW     = 3
) ();

   // Transform request from the polynomial controller
   logic              start;
   logic              inverse;

   // Beat stream towards coefficient RAM / twiddle ROM / butterfly unit
   logic              ready;
   logic              valid;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [ADDR_W-1:0] zeta_idx;
   logic [LW-1:0]     layer;
   logic              scale;

   // Transform status
   logic              busy;
   logic              done;

   // Sequencer side: sources the beat stream and status
   modport master (
      input  start, inverse, ready,
      output valid, addr_a, addr_b, zeta_idx, layer, scale, busy, done
   );

   // Controller / datapath side
   modport slave (
      output start, inverse, ready,
      input  valid, addr_a, addr_b, zeta_idx, layer, scale, busy, done
   );

endinterface

// File: rtl/ntt_addr_sequencer.sv
// rtl/ntt_addr_sequencer.sv - layer/group/offset sequencer for the Dilithium NTT/INTT butterfly datapath
module ntt_addr_sequencer #(
   parameter int LOG_N  = 8,
   parameter int ADDR_W = LOG_N
) (
   input  logic                  clk,
   input  logic                  rst,
   ntt_addr_sequencer_if.master  bus
);

   localparam int LW = $clog2(LOG_N);
   localparam int BW = LOG_N - 1;

   localparam logic [BW-1:0]     B_LAST = '1;
   localparam logic [LW-1:0]     L_LAST = LW'(LOG_N - 1);
   localparam logic [ADDR_W-1:0] S_LAST = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BFLY  = 2'd1,
      SCALE = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LW-1:0]     l_q, l_d;
   logic [BW-1:0]     b_q, b_d;
   logic [ADDR_W-1:0] s_q, s_d;
   logic              mode_q, mode_d;

   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              scale_q, scale_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [ADDR_W-1:0] zeta_q, zeta_d;
   logic [LW-1:0]     layer_q, layer_d;

   logic              accept;

   // Butterfly geometry derived from the next-cycle counters
   int                k;
   int                grp;
   int                off;
   int                aa;
   int                zf;
   int                zi;

   // State register, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         l_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         mode_q   <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         scale_q  <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         zeta_q   <= '0;
         layer_q  <= '0;
      end else begin
         state_q  <= state_d;
         l_q      <= l_d;
         b_q      <= b_d;
         s_q      <= s_d;
         mode_q   <= mode_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         scale_q  <= scale_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         zeta_q   <= zeta_d;
         layer_q  <= layer_d;
      end
   end

   // Next state and counter advance; counters only move on an accepted beat
   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      b_d     = b_q;
      s_d     = s_q;
      mode_d  = mode_q;
      accept  = valid_q & bus.ready;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = BFLY;
               l_d     = '0;
               b_d     = '0;
               s_d     = '0;
               mode_d  = bus.inverse;
            end
         end
         BFLY: begin
            if (accept) begin
               if (b_q == B_LAST) begin
                  b_d = '0;
                  if (l_q == L_LAST) begin
                     l_d     = '0;
                     state_d = mode_q ? SCALE : FIN;
                  end else begin
                     l_d = l_q + 1'b1;
                  end
               end else begin
                  b_d = b_q + 1'b1;
               end
            end
         end
         SCALE: begin
            if (accept) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  state_d = FIN;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address and twiddle index for the beat presented next cycle
   always_comb begin
      // log2(len): shrinking span for Cooley-Tukey, growing span for Gentleman-Sande
      k   = mode_d ? int'(l_d) : (LOG_N - 1 - int'(l_d));
      grp = int'(b_d) >> k;
      off = int'(b_d) & ((1 << k) - 1);
      aa  = (grp << (k + 1)) + off;
      zf  = (1 << int'(l_d)) + grp;
      zi  = (1 << (LOG_N - int'(l_d))) - 1 - grp;
   end

   // Output values registered alongside the state so every output is a flop
   always_comb begin
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      scale_d  = 1'b0;
      addr_a_d = '0;
      addr_b_d = '0;
      zeta_d   = '0;
      layer_d  = '0;

      case (state_d)
         BFLY: begin
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            addr_a_d = ADDR_W'(aa);
            addr_b_d = ADDR_W'(aa + (1 << k));
            zeta_d   = mode_d ? ADDR_W'(zi) : ADDR_W'(zf);
            layer_d  = l_d;
         end
         SCALE: begin
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            scale_d  = 1'b1;
            addr_a_d = s_d;
            addr_b_d = s_d;
         end
         FIN: begin
            done_d = 1'b1;
         end
         default: begin
            valid_d = 1'b0;
         end
      endcase
   end

   assign bus.valid    = valid_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.scale    = scale_q;
   assign bus.addr_a   = addr_a_q;
   assign bus.addr_b   = addr_b_q;
   assign bus.zeta_idx = zeta_q;
   assign bus.layer    = layer_q;

endmodule

// File: tb/tb_ntt_addr_sequencer.sv
// tb/tb_ntt_addr_sequencer.sv - scoreboard bench for the NTT address sequencer
module tb_ntt_addr_sequencer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ntt_addr_sequencer_if #(.ADDR_W(8), .LW(3)) bus ();

   ntt_addr_sequencer #(.LOG_N(8), .ADDR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] z;
      logic [2:0] layer;
      logic       scale;
   } beat_t;

   beat_t exp_q[$];
   int    n_pass  = 0;
   int    n_total = 0;

   function automatic beat_t obs();
      return {bus.addr_a, bus.addr_b, bus.zeta_idx, bus.layer, bus.scale};
   endfunction

   // Reference loop nest of the Dilithium ntt()/invntt() routines
   task automatic push_expected(input bit inv);
      int kz;
      int li;
      exp_q.delete();
      li = 0;
      if (!inv) begin
         kz = 0;
         for (int len = 128; len > 0; len = len >> 1) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
               kz++;
               for (int j = st; j < st + len; j++)
                  exp_q.push_back('{8'(j), 8'(j + len), 8'(kz), 3'(li), 1'b0});
            end
            li++;
         end
      end else begin
         kz = 256;
         for (int len = 1; len < 256; len = len << 1) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
               kz--;
               for (int j = st; j < st + len; j++)
                  exp_q.push_back('{8'(j), 8'(j + len), 8'(kz), 3'(li), 1'b0});
            end
            li++;
         end
         for (int s = 0; s < 256; s++)
            exp_q.push_back('{8'(s), 8'(s), 8'd0, 3'd0, 1'b1});
      end
   endtask

   // Called at a falling edge; returns at the falling edge where beat0 should be visible
   task automatic do_start(input bit inv);
      bus.start   = 1'b1;
      bus.inverse = inv;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.inverse = 1'b0;
   endtask

   // Drains a whole transform against the scoreboard; returns at the expected done cycle
   task automatic run_beats(input bit inv, input int stall_at, input int stall_len,
                            input int pulse_at, input string tag);
      int    total;
      int    n;
      int    cyc;
      int    stalled;
      bit    pulsed;
      bit    spot;
      beat_t e;
      beat_t o;
      beat_t sv;
      push_expected(inv);
      total   = exp_q.size();
      n       = 0;
      cyc     = 0;
      stalled = 0;
      pulsed  = 1'b0;
      while (n < total && cyc < 4000) begin
         if (pulse_at >= 0 && n == pulse_at && !pulsed) begin
            bus.start   = 1'b1;
            bus.inverse = 1'b1;
            pulsed      = 1'b1;
         end else begin
            bus.start   = 1'b0;
            bus.inverse = 1'b0;
         end
         o = obs();
         if (n == stall_at && stalled < stall_len) begin
            bus.ready = 1'b0;
            stalled++;
            n_total++;
            if (bus.valid !== 1'b1 || o !== exp_q[0])
               $display("FAIL %s stall_hold beat %0d: got valid=%b beat=%h, want valid=1 beat=%h",
                        tag, n, bus.valid, o, exp_q[0]);
            else
               n_pass++;
         end else begin
            bus.ready = 1'b1;
            if (bus.valid === 1'b1) begin
               e = exp_q.pop_front();
               n_total++;
               if (o !== e || bus.busy !== 1'b1 || bus.done !== 1'b0)
                  $display("FAIL %s beat %0d: got beat=%h busy=%b done=%b, want beat=%h busy=1 done=0",
                           tag, n, o, bus.busy, bus.done, e);
               else
                  n_pass++;
               spot = 1'b1;
               sv   = '0;
               if (!inv) begin
                  case (n)
                     0:       sv = '{8'd0,   8'd128, 8'd1,   3'd0, 1'b0};
                     1:       sv = '{8'd1,   8'd129, 8'd1,   3'd0, 1'b0};
                     128:     sv = '{8'd0,   8'd64,  8'd2,   3'd1, 1'b0};
                     192:     sv = '{8'd128, 8'd192, 8'd3,   3'd1, 1'b0};
                     1023:    sv = '{8'd254, 8'd255, 8'd255, 3'd7, 1'b0};
                     default: spot = 1'b0;
                  endcase
               end else begin
                  case (n)
                     0:       sv = '{8'd0,   8'd1,   8'd255, 3'd0, 1'b0};
                     1:       sv = '{8'd2,   8'd3,   8'd254, 3'd0, 1'b0};
                     1023:    sv = '{8'd127, 8'd255, 8'd1,   3'd7, 1'b0};
                     1024:    sv = '{8'd0,   8'd0,   8'd0,   3'd0, 1'b1};
                     1279:    sv = '{8'd255, 8'd255, 8'd0,   3'd0, 1'b1};
                     default: spot = 1'b0;
                  endcase
               end
               if (spot) begin
                  n_total++;
                  if (o !== sv)
                     $display("FAIL %s spot beat %0d: got %h, want %h", tag, n, o, sv);
                  else
                     n_pass++;
               end
               n++;
            end else begin
               n_total++;
               $display("FAIL %s valid_dropped at beat %0d: got valid=%b, want 1", tag, n, bus.valid);
               cyc = 4000;
            end
         end
         @(negedge clk);
         cyc++;
      end
      bus.start   = 1'b0;
      bus.inverse = 1'b0;
      n_total++;
      if (n != total)
         $display("FAIL %s beat_count: got %0d, want %0d", tag, n, total);
      else
         n_pass++;
      n_total++;
      if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL %s fin_cycle: got done=%b valid=%b busy=%b, want done=1 valid=0 busy=0",
                  tag, bus.done, bus.valid, bus.busy);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.inverse = 1'b0;
      bus.ready   = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.valid, bus.busy, bus.done, obs()} !== '0)
         $display("FAIL reset_outputs: got %h, want 0", {bus.valid, bus.busy, bus.done, obs()});
      else
         n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.valid, bus.busy, bus.done, obs()} !== '0)
         $display("FAIL idle_outputs: got %h, want 0", {bus.valid, bus.busy, bus.done, obs()});
      else
         n_pass++;
   endtask

   task automatic test_forward();
      do_start(1'b0);
      run_beats(1'b0, -1, 0, -1, "fwd");
      @(negedge clk);
      n_total++;
      if (bus.done !== 1'b0 || bus.valid !== 1'b0)
         $display("FAIL fwd done_width: got done=%b valid=%b, want 0 0", bus.done, bus.valid);
      else
         n_pass++;
   endtask

   task automatic test_inverse();
      do_start(1'b1);
      run_beats(1'b1, -1, 0, -1, "inv");
      @(negedge clk);
      n_total++;
      if (bus.done !== 1'b0 || bus.valid !== 1'b0)
         $display("FAIL inv done_width: got done=%b valid=%b, want 0 0", bus.done, bus.valid);
      else
         n_pass++;
   endtask

   // Stall at beat 300 and an inverse start pulse at beat 50 in one forward run
   task automatic test_backpressure_busy_start();
      do_start(1'b0);
      run_beats(1'b0, 300, 5, 50, "bp");
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      int cyc;
      do_start(1'b0);
      n   = 0;
      cyc = 0;
      bus.ready = 1'b1;
      while (n < 400 && cyc < 1000) begin
         if (bus.valid === 1'b1) n++;
         @(negedge clk);
         cyc++;
      end
      n_total++;
      if (bus.layer !== 3'd3 || bus.valid !== 1'b1)
         $display("FAIL rstmid layer: got layer=%0d valid=%b, want 3 1", bus.layer, bus.valid);
      else
         n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({bus.valid, bus.busy, bus.done, obs()} !== '0)
         $display("FAIL rstmid async_clear: got %h, want 0", {bus.valid, bus.busy, bus.done, obs()});
      else
         n_pass++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) rst = 1'b0;
         n_total++;
         if (bus.done !== 1'b0 || bus.valid !== 1'b0)
            $display("FAIL rstmid no_done cycle %0d: got done=%b valid=%b, want 0 0", i, bus.done, bus.valid);
         else
            n_pass++;
      end
      @(negedge clk);
      do_start(1'b0);
      run_beats(1'b0, -1, 0, -1, "restart");
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_start(1'b0);
      run_beats(1'b0, -1, 0, -1, "b2b_fwd");
      bus.start   = 1'b1;
      bus.inverse = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL b2b start_in_done_ignored: got valid=%b busy=%b done=%b, want 0 0 0",
                  bus.valid, bus.busy, bus.done);
      else
         n_pass++;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.inverse = 1'b0;
      run_beats(1'b1, -1, 0, -1, "b2b_inv");
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_backpressure_busy_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
